// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  // Iteration counter must hold the value DIVIDEND_W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   part,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   part_nxt,
  output logic                 qbit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  // A restored partial is always below the divisor, so the difference fits in DIVISOR_W+1 bits.
  assign shifted  = {part, din};
  assign diff     = shifted[DIVISOR_W:0] - {1'b0, divisor};
  assign qbit     = (shifted >= {2'b00, divisor});
  assign part_nxt = qbit ? diff : shifted[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle with start/done handshake.
// Optional macro SEQ_DIVIDER_DBZ_FAST_EN: a zero divisor finishes one cycle after acceptance.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  dbz
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    part;
  logic [DIVISOR_W:0]    part_nxt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVIDEND_W-2:0] qsh;
  logic [DIVISOR_W-1:0]  dsr;
  logic                  qbit;
  logic                  dsr_zero;
  logic [CNT_W-1:0]      cnt_init;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .part     (part),
    .din      (dvd[DIVIDEND_W-1]),
    .divisor  (dsr),
    .part_nxt (part_nxt),
    .qbit     (qbit)
  );

  assign dsr_zero = (dsr == '0);

`ifdef SEQ_DIVIDER_DBZ_FAST_EN
  assign cnt_init = (divisor == '0) ? CNT_W'(1) : CNT_W'(DIVIDEND_W);
`else
  assign cnt_init = CNT_W'(DIVIDEND_W);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      part  <= '0;
      dvd   <= '0;
      qsh   <= '0;
      dsr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd   <= dividend;
            dsr   <= divisor;
            part  <= '0;
            qsh   <= '0;
            cnt   <= cnt_init;
            busy  <= 1'b1;
            state <= RUN;
            if (divisor != '0) dbz <= 1'b0;
          end
        end
        RUN: begin
          // Iteration stage: consume one dividend MSB, emit one quotient bit
          dvd  <= dvd << 1;
          part <= part_nxt;
          qsh  <= {qsh[DIVIDEND_W-3:0], qbit};
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
            if (dsr_zero) begin
              quot <= '1;
              rem  <= '0;
              dbz  <= 1'b1;
            end else begin
              quot <= {qsh, qbit};
              rem  <= part_nxt[DIVISOR_W-1:0];
              dbz  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse companion to the combinational wallace multiplier.
- Takes an 8-bit dividend (a multiplier product) and a 4-bit divisor, and returns quotient and remainder after a fixed number of cycles.
- Used to check multiplier results in-system and as a standalone arithmetic unit.
- Start/done handshake, one quotient bit per cycle.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only while busy=0.
- dividend  input  DIVIDEND_W  numerator; captured on the accepting edge.
- divisor  input  DIVISOR_W  denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse when results become valid.
- quot  output  DIVIDEND_W  quotient, unsigned.
- rem  output  DIVISOR_W  remainder, unsigned.
- dbz  output  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, dbz = 0; quot, rem = 0; internal counter and partial remainder = 0.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at an edge, capture dividend and divisor, clear the partial remainder (DIVISOR_W+1 bits) and the quotient shift register.
  - Set count=DIVIDEND_W, busy=1, done=0, then go to RUN.
  - If start=0, hold all outputs.
- RUN, one iteration per edge:
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - If partial ≥ divisor: subtract the divisor and shift in quotient bit 1. Otherwise shift in 0.
  - Decrement count.
  - On the edge where count reaches 0: register quot and rem, set done=1 and busy=0, return to IDLE.
- Latency: start accepted at edge 0; done visible after edge DIVIDEND_W (8) for exactly one cycle.
- Results hold until the next accepted start.
- start while busy=1: ignored; no queueing, captured operands unchanged.
- start high in the same cycle done=1: accepted (state is IDLE); done drops at that edge and busy rises.
- Operand inputs may change freely after the accepting edge.
- Divisor=0:
  - Runs normal latency.
  - Outputs forced to quot = all ones, rem = 0, dbz = 1.
- dbz is cleared on the next accepted start with a nonzero divisor.
- Reset mid-RUN aborts the operation; no done pulse is issued.
- Arithmetic is unsigned. Invariant: quot*divisor + rem == dividend and rem < divisor, for divisor ≠ 0.

Optional Feature:
- Macro: SEQ_DIVIDER_DBZ_FAST_EN.
- Defined: a zero divisor is detected at the accepting edge and the block skips RUN. done and dbz are asserted after edge 1, with quot = all ones and rem = 0.
- Undefined: a zero divisor takes the full DIVIDEND_W-cycle latency, with the same forced outputs.

Decomposition:
- Package seq_divider_pkg holds:
  - state enum (IDLE, RUN);
  - default width constants;
  - counter width as $clog2(DIVIDEND_W+1).
- Sub-module div_step: combinational single iteration. Inputs are the partial remainder, incoming dividend bit and divisor; outputs are the next partial remainder and the quotient bit.
- The top level holds the FSM, counter and registers.

Test Plan:
- dividend=200, divisor=7, start pulse → done exactly 8 cycles later; quot=28, rem=4, dbz=0, busy high for 8 cycles.
- dividend=225, divisor=15, then back-to-back start on the done cycle with 255/1 → first quot=15, rem=0; second quot=255, rem=0; no idle gap.
- dividend=77, divisor=0 → quot=255, rem=0, dbz=1. Latency is 8 cycles without the macro, 1 cycle with SEQ_DIVIDER_DBZ_FAST_EN.
- 100/3 in flight, start pulse with 50/5 at cycle 3 → second request ignored; quot=33, rem=1.
- 200/7 started, rst asserted at cycle 4 (between edges) → outputs zero immediately, no done; next 9/2 → quot=4, rem=1.
- Exhaustive sweep over all 256 dividends × divisors 1..15: result matches dividend/divisor and dividend%divisor; error count must be 0.
